// File: rtl/result_scoreboard.sv
// In-order scoreboard: queues model and DUT memory-access results, pairs them,
// and emits one compare record per pair with match/mismatch counters and a stall watchdog.
module rs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Extra wrap bit distinguishes full from empty when the index bits agree.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module result_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 256,
  parameter int ERR_ONLY = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     mdl_valid,
  output logic                     mdl_ready,
  input  logic [DATA_W-1:0]        mdl_data,
  input  logic [ADDR_W-1:0]        mdl_addr,
  input  logic                     mdl_dir,
  input  logic                     dut_valid,
  output logic                     dut_ready,
  input  logic [DATA_W-1:0]        dut_data,
  input  logic [ADDR_W-1:0]        dut_addr,
  input  logic                     dut_dir,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W+ADDR_W:0]   res_mdl,
  output logic [DATA_W+ADDR_W:0]   res_dut,
  output logic [2:0]               res_err,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mis_cnt,
  output logic                     timeout
);
  localparam int EW   = DATA_W + ADDR_W + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              dir;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Index 0 is the model stream, index 1 the DUT stream.
  logic [1:0]         push, empty, full;
  logic [1:0][EW-1:0] wdata, rdata;
  logic               up, fire, emit, one_side;
  logic [2:0]         err_c;
  entry_t             me, de;
  logic [WD_W-1:0]    wd_cnt;

  // Ready held low until the first clock after reset so every output reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) up <= 1'b0;
    else        up <= 1'b1;
  end

  assign mdl_ready = up && !full[0];
  assign dut_ready = up && !full[1];
  assign push[0]   = mdl_valid && mdl_ready;
  assign push[1]   = dut_valid && dut_ready;
  assign wdata[0]  = {mdl_dir, mdl_addr, mdl_data};
  assign wdata[1]  = {dut_dir, dut_addr, dut_data};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    rs_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[g]),
      .pop   (fire),
      .wdata (wdata[g]),
      .rdata (rdata[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  assign me       = entry_t'(rdata[0]);
  assign de       = entry_t'(rdata[1]);
  assign err_c    = {me.dir != de.dir, me.addr != de.addr, me.data != de.data};
  assign fire     = !empty[0] && !empty[1] && (!res_valid || res_ready) && !flush;
  assign emit     = fire && ((err_c != 3'b000) || (ERR_ONLY == 0));
  assign one_side = empty[0] ^ empty[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_mdl   <= '0;
      res_dut   <= '0;
      res_err   <= '0;
      match_cnt <= '0;
      mis_cnt   <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else begin
      if (emit) begin
        res_valid <= 1'b1;
        res_mdl   <= rdata[0];
        res_dut   <= rdata[1];
        res_err   <= err_c;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (fire && err_c == 3'b000 && match_cnt != {CNT_W{1'b1}}) match_cnt <= match_cnt + 1'b1;
      if (fire && err_c != 3'b000 && mis_cnt   != {CNT_W{1'b1}}) mis_cnt   <= mis_cnt + 1'b1;
    end
  end

  // Watchdog: one side starved for TIMEOUT consecutive cycles latches timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (flush || !one_side) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_W'(TIMEOUT))     wd_cnt  <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: one instance with ERR_ONLY=0, one with ERR_ONLY=1, shared stimulus.
module tb_result_scoreboard;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, rr = 1'b1;
  logic        mv = 1'b0, mdir = 1'b0, dv = 1'b0, ddir = 1'b0;
  logic [31:0] md = '0, ma = '0, dd = '0, da = '0;

  logic        mrdy0, drdy0, rv0, to0, mrdy1, drdy1, rv1, to1;
  logic [64:0] rm0, rd0, rm1, rd1;
  logic [2:0]  re0, re1;
  logic [15:0] mc0, xc0, mc1, xc1;

  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  result_scoreboard #(.ERR_ONLY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mdl_valid(mv), .mdl_ready(mrdy0), .mdl_data(md), .mdl_addr(ma), .mdl_dir(mdir),
    .dut_valid(dv), .dut_ready(drdy0), .dut_data(dd), .dut_addr(da), .dut_dir(ddir),
    .res_valid(rv0), .res_ready(rr), .res_mdl(rm0), .res_dut(rd0), .res_err(re0),
    .match_cnt(mc0), .mis_cnt(xc0), .timeout(to0));

  result_scoreboard #(.ERR_ONLY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mdl_valid(mv), .mdl_ready(mrdy1), .mdl_data(md), .mdl_addr(ma), .mdl_dir(mdir),
    .dut_valid(dv), .dut_ready(drdy1), .dut_data(dd), .dut_addr(da), .dut_dir(ddir),
    .res_valid(rv1), .res_ready(rr), .res_mdl(rm1), .res_dut(rd1), .res_err(re1),
    .match_cnt(mc1), .mis_cnt(xc1), .timeout(to1));

  typedef struct {
    logic [31:0] md, ma;
    logic        mdir;
    logic [31:0] dd, da;
    logic        ddir;
    logic [2:0]  err;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[7];
    int em, ex, p0, p1;
    logic [2:0]  cap_err;
    logic [31:0] cap_data;
    logic [64:0] e;

    vt[0] = '{32'hDEADBEEF, 32'h1000, 1'b1, 32'hDEADBEEF, 32'h1000, 1'b1, 3'b000};
    vt[1] = '{32'hDEADBEEF, 32'h1000, 1'b1, 32'hDEADBEEE, 32'h1004, 1'b0, 3'b111};
    vt[2] = '{32'h12345678, 32'h0040, 1'b0, 32'h12345679, 32'h0040, 1'b0, 3'b001};
    vt[3] = '{32'h12345678, 32'h0040, 1'b0, 32'h12345678, 32'h0044, 1'b0, 3'b010};
    vt[4] = '{32'h12345678, 32'h0040, 1'b0, 32'h12345678, 32'h0040, 1'b1, 3'b100};
    vt[5] = '{32'h00000000, 32'h0000, 1'b0, 32'h00000000, 32'h0000, 1'b0, 3'b000};
    vt[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b000};

    // Reset state
    tick(); tick();
    chk("reset_res_valid", rv0, 0);
    chk("reset_mdl_ready", mrdy0, 0);
    chk("reset_match_cnt", mc0, 0);
    chk("reset_mis_cnt", xc0, 0);
    chk("reset_timeout", to0, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post_reset_mdl_ready", mrdy0, 1);
    chk("post_reset_dut_ready", drdy0, 1);

    // Table: one pair per entry, record expected one cycle after the compare
    em = 0; ex = 0;
    for (int i = 0; i < 7; i++) begin
      mv = 1'b1; md = vt[i].md; ma = vt[i].ma; mdir = vt[i].mdir;
      dv = 1'b1; dd = vt[i].dd; da = vt[i].da; ddir = vt[i].ddir;
      tick();
      mv = 1'b0; dv = 1'b0;
      tick();
      if (vt[i].err == 3'b000) em++; else ex++;
      chk($sformatf("vec%0d_valid", i), rv0, 1);
      chk($sformatf("vec%0d_err", i), re0, vt[i].err);
      chk($sformatf("vec%0d_res_mdl", i), rm0, {vt[i].mdir, vt[i].ma, vt[i].md});
      chk($sformatf("vec%0d_res_dut", i), rd0, {vt[i].ddir, vt[i].da, vt[i].dd});
      chk($sformatf("vec%0d_match_cnt", i), mc0, em);
      chk($sformatf("vec%0d_mis_cnt", i), xc0, ex);
    end
    tick();
    chk("table_drain_valid", rv0, 0);

    // Fill model FIFO to DEPTH, then stream matching DUT entries
    for (int i = 0; i < 8; i++) begin
      mv = 1'b1; md = 32'hA0000000 + i; ma = 32'h2000 + 4 * i; mdir = i[0];
      tick();
      if (i == 6) chk("fill7_mdl_ready", mrdy0, 1);
    end
    mv = 1'b0;
    chk("full_mdl_ready", mrdy0, 0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        dv = 1'b1; dd = 32'hA0000000 + i; da = 32'h2000 + 4 * i; ddir = i[0];
      end else dv = 1'b0;
      tick();
      if (i > 0) begin
        e = {i[0] ^ 1'b1, 32'h2000 + 4 * (i - 1), 32'hA0000000 + (i - 1)};
        chk($sformatf("stream%0d_valid", i - 1), rv0, 1);
        chk($sformatf("stream%0d_res_mdl", i - 1), rm0, e);
        chk($sformatf("stream%0d_res_dut", i - 1), rd0, e);
      end
    end
    em += 8;
    chk("stream_match_cnt", mc0, em);
    tick();
    chk("stream_drain_valid", rv0, 0);
    chk("stream_mdl_ready", mrdy0, 1);

    // Backpressure: record held, FIFOs keep pending pairs
    rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mv = 1'b1; md = 32'hB0 + i; ma = 32'h3000 + i; mdir = 1'b0;
      dv = 1'b1; dd = 32'hB0 + i; da = 32'h3000 + i; ddir = 1'b0;
      tick();
    end
    mv = 1'b0; dv = 1'b0;
    repeat (3) tick();
    chk("hold_valid", rv0, 1);
    chk("hold_res_mdl", rm0, {1'b0, 32'h3000, 32'hB0});
    chk("hold_match_cnt", mc0, em + 1);
    rr = 1'b1;
    tick();
    chk("release1_valid", rv0, 1);
    chk("release1_res_dut", rd0, {1'b0, 32'h3001, 32'hB1});
    chk("release1_match_cnt", mc0, em + 2);
    tick();
    chk("release2_res_dut", rd0, {1'b0, 32'h3002, 32'hB2});
    tick();
    chk("release_drain_valid", rv0, 0);
    em += 3;
    chk("release_match_cnt", mc0, em);

    // Watchdog: single model entry starves the pairing
    mv = 1'b1; md = 32'h55; ma = 32'h5000; mdir = 1'b1;
    tick();
    mv = 1'b0;
    repeat (255) @(posedge clk);
    #1;
    chk("wd_before_limit", to0, 0);
    tick();
    chk("wd_at_limit", to0, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_timeout_sticky", to0, 1);
    chk("flush_res_valid", rv0, 0);
    dv = 1'b1; dd = 32'h55; da = 32'h5000; ddir = 1'b1;
    tick();
    dv = 1'b0;
    tick(); tick();
    chk("flush_emptied_no_pair", rv0, 0);
    chk("flush_keeps_match_cnt", mc0, em);
    chk("flush_keeps_mis_cnt", xc0, ex);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset clears sticky timeout; then ERR_ONLY stream on instance 1
    rst_n = 1'b0;
    #2;
    chk("reset2_timeout", to1, 0);
    chk("reset2_match_cnt", mc1, 0);
    chk("reset2_mdl_ready", mrdy1, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    p0 = 0; p1 = 0; cap_err = '0; cap_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        mv = 1'b1; md = 32'hC0 + i; ma = 32'h4000 + i; mdir = 1'b1;
        dv = 1'b1; dd = (i == 2) ? (32'hC0 + i) ^ 32'h1 : 32'hC0 + i; da = 32'h4000 + i; ddir = 1'b1;
      end else begin
        mv = 1'b0; dv = 1'b0;
      end
      tick();
      if (rv0) p0++;
      if (rv1) begin
        p1++; cap_err = re1; cap_data = rd1[31:0];
      end
    end
    chk("erronly_pulses", p1, 1);
    chk("erronly_err", cap_err, 3'b001);
    chk("erronly_dut_data", cap_data, 32'hC3);
    chk("erronly_match_cnt", mc1, 3);
    chk("erronly_mis_cnt", xc1, 1);
    chk("all_records_pulses", p0, 4);

    // Reset mid-stream with a record held
    rr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mv = 1'b1; md = 32'hE0 + i; ma = 32'h6000; mdir = 1'b0;
      dv = 1'b1; dd = 32'hE0 + i; da = 32'h6000; ddir = 1'b0;
      tick();
    end
    mv = 1'b0; dv = 1'b0;
    tick();
    chk("pre_reset_valid", rv0, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", rv0, 0);
    chk("midreset_res_mdl", rm0, 0);
    chk("midreset_match_cnt", mc0, 0);
    chk("midreset_mis_cnt", xc1, 0);
    chk("midreset_mdl_ready", mrdy0, 0);
    tick();
    rst_n = 1'b1; rr = 1'b1;
    repeat (3) tick();
    chk("after_reset_no_record", rv0, 0);
    chk("after_reset_match_cnt", mc0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
